blackparrot_fpga_host_nbf_axil: RTL and testbench

//  AXI4-Lite slave that receives 32b NBF flits written by the host and buffers them in a FIFO.

---
 rtl/blackparrot_fpga_host_pkg.sv | 28 ++
 rtl/bsg_fifo_1r1w_small.sv | 59 +++++
 rtl/blackparrot_fpga_host_nbf_axil.sv | 173 +++++++++++++++++
 tb/tb_blackparrot_fpga_host_nbf_axil.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blackparrot_fpga_host_pkg.sv
// Shared constants and the register decode for the NBF host AXI-Lite slave.
package blackparrot_fpga_host_pkg;

    localparam logic [3:0] nbf_data_addr_gp  = 4'h0;
    localparam logic [3:0] nbf_free_addr_gp  = 4'h4;
    localparam logic [3:0] nbf_count_addr_gp = 4'h8;

    localparam logic [1:0] axi_resp_okay_gp   = 2'b00;
    localparam logic [1:0] axi_resp_slverr_gp = 2'b10;

    typedef enum logic [1:0] {
        e_reg_data,
        e_reg_free,
        e_reg_count,
        e_reg_none
    } nbf_reg_e;

    // Map the low address nibble onto one of the three registers.
    function automatic nbf_reg_e decode_addr(input logic [3:0] addr);
        unique case (addr)
            nbf_data_addr_gp:  return e_reg_data;
            nbf_free_addr_gp:  return e_reg_free;
            nbf_count_addr_gp: return e_reg_count;
            default:           return e_reg_none;
        endcase
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with a valid/ready input and valid/yumi output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 32,
    parameter int els_p   = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w = $clog2(els_p);

    logic [ptr_w:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [width_p-1:0]   mem_q [els_p];
    logic                 empty, full, push, pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[ptr_w] != rptr_q[ptr_w])
                  && (wptr_q[ptr_w-1:0] == rptr_q[ptr_w-1:0]);
    assign ready_o = ~full;
    assign v_o     = ~empty;
    assign data_o  = mem_q[rptr_q[ptr_w-1:0]];
    assign push    = v_i & ~full;
    assign pop     = yumi_i & ~empty;

    // Advance pointers on accepted push and pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = wptr_q + (ptr_w+1)'(1);
        if (pop)  rptr_d = rptr_q + (ptr_w+1)'(1);
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Flit storage.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
        if (push) mem_q[wptr_q[ptr_w-1:0]] <= data_i;
    end

endmodule

// File: rtl/blackparrot_fpga_host_nbf_axil.sv
// AXI-Lite slave that accepts NBF flits from the host, buffers them in a FIFO
// and streams them out, exposing free space and a pushed-flit count for throttling.
module blackparrot_fpga_host_nbf_axil
    import blackparrot_fpga_host_pkg::*;
#(
    parameter int S_AXIL_ADDR_WIDTH = 32,
    parameter int S_AXIL_DATA_WIDTH = 32,
    parameter int fifo_els_p        = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [S_AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                         s_axil_awvalid,
    output logic                         s_axil_awready,
    input  logic [S_AXIL_DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [3:0]                   s_axil_wstrb,
    input  logic                         s_axil_wvalid,
    output logic                         s_axil_wready,
    output logic [1:0]                   s_axil_bresp,
    output logic                         s_axil_bvalid,
    input  logic                         s_axil_bready,
    input  logic [S_AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                         s_axil_arvalid,
    output logic                         s_axil_arready,
    output logic [S_AXIL_DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    output logic                         s_axil_rvalid,
    input  logic                         s_axil_rready,
    output logic                         nbf_v_o,
    output logic [31:0]                  nbf_data_o,
    input  logic                         nbf_ready_and_i
);

    localparam int occ_w = $clog2(fifo_els_p) + 1;

    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [3:0]        aw_addr_q, aw_addr_d, w_strb_q, w_strb_d;
    logic [31:0]       w_data_q, w_data_d;
    logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]       rdata_q, rdata_d, count_q, count_d, free_w;
    logic [occ_w-1:0]  occ_q, occ_d;
    logic              fifo_ready, fifo_push, fifo_pop, push_ok, commit;
    logic              unused_addr_bits;

    // Only the low nibble of each address is decoded.
    assign unused_addr_bits = ^{s_axil_awaddr[S_AXIL_ADDR_WIDTH-1:4], s_axil_araddr[S_AXIL_ADDR_WIDTH-1:4]};

    assign s_axil_awready = ~aw_held_q;
    assign s_axil_wready  = ~w_held_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = ~rvalid_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;

    assign fifo_pop = nbf_v_o & nbf_ready_and_i;
    assign free_w   = 32'(fifo_els_p) - 32'(occ_q);

    // Write path: independent AW/W capture, then a single commit that may push a flit.
    always_comb begin
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        push_ok   = (decode_addr(aw_addr_q) == e_reg_data) && (w_strb_q == 4'hF);
        // A good data write waits for FIFO space; anything else commits immediately as an error.
        commit    = aw_held_q & w_held_q & ~bvalid_q & (~push_ok | fifo_ready);
        fifo_push = commit & push_ok;
        if (s_axil_awvalid && !aw_held_q) begin
            aw_held_d = 1'b1;
            aw_addr_d = s_axil_awaddr[3:0];
        end
        if (s_axil_wvalid && !w_held_q) begin
            w_held_d = 1'b1;
            w_data_d = s_axil_wdata;
            w_strb_d = s_axil_wstrb;
        end
        if (bvalid_q && s_axil_bready) bvalid_d = 1'b0;
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = push_ok ? axi_resp_okay_gp : axi_resp_slverr_gp;
        end
        count_d = fifo_push ? count_q + 32'd1 : count_q;
    end

    // Occupancy tracks the FIFO so free space can be reported without peeking at pointers.
    always_comb begin
        unique case ({fifo_push, fifo_pop})
            2'b10:   occ_d = occ_q + occ_w'(1);
            2'b01:   occ_d = occ_q - occ_w'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Read path: register the addressed value in the AR-accept cycle.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (s_axil_arvalid && !rvalid_q) begin
            rvalid_d = 1'b1;
            unique case (decode_addr(s_axil_araddr[3:0]))
                e_reg_free: begin
                    rdata_d = free_w;
                    rresp_d = axi_resp_okay_gp;
                end
                e_reg_count: begin
                    rdata_d = count_q;
                    rresp_d = axi_resp_okay_gp;
                end
                default: begin
                    rdata_d = 32'd0;
                    rresp_d = axi_resp_slverr_gp;
                end
            endcase
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // State registers for both channels and the counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= axi_resp_okay_gp;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= axi_resp_okay_gp;
            count_q   <= '0;
            occ_q     <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            count_q   <= count_d;
            occ_q     <= occ_d;
        end
    end

    bsg_fifo_1r1w_small #(
        .width_p (32),
        .els_p   (fifo_els_p)
    ) u_flit_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (fifo_push),
        .ready_o (fifo_ready),
        .data_i  (w_data_q),
        .v_o     (nbf_v_o),
        .data_o  (nbf_data_o),
        .yumi_i  (fifo_pop)
    );

endmodule

// File: tb/tb_blackparrot_fpga_host_nbf_axil.sv
// Directed bench for the NBF AXI-Lite host slave.
module tb_blackparrot_fpga_host_nbf_axil;
    import blackparrot_fpga_host_pkg::*;

    localparam int els = 16;
    localparam int tmo = 300;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata, nbf_data_o;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
    logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
    logic        s_axil_rvalid, s_axil_rready, nbf_v_o, nbf_ready_and_i;
    logic [1:0]  s_axil_bresp, s_axil_rresp;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rcv_q[$];
    logic [31:0] wdat, rdat;
    logic [1:0]  resp;
    bit          t5_done;

    blackparrot_fpga_host_nbf_axil #(
        .S_AXIL_ADDR_WIDTH (32),
        .S_AXIL_DATA_WIDTH (32),
        .fifo_els_p        (els)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .s_axil_awaddr   (s_axil_awaddr),
        .s_axil_awvalid  (s_axil_awvalid),
        .s_axil_awready  (s_axil_awready),
        .s_axil_wdata    (s_axil_wdata),
        .s_axil_wstrb    (s_axil_wstrb),
        .s_axil_wvalid   (s_axil_wvalid),
        .s_axil_wready   (s_axil_wready),
        .s_axil_bresp    (s_axil_bresp),
        .s_axil_bvalid   (s_axil_bvalid),
        .s_axil_bready   (s_axil_bready),
        .s_axil_araddr   (s_axil_araddr),
        .s_axil_arvalid  (s_axil_arvalid),
        .s_axil_arready  (s_axil_arready),
        .s_axil_rdata    (s_axil_rdata),
        .s_axil_rresp    (s_axil_rresp),
        .s_axil_rvalid   (s_axil_rvalid),
        .s_axil_rready   (s_axil_rready),
        .nbf_v_o         (nbf_v_o),
        .nbf_data_o      (nbf_data_o),
        .nbf_ready_and_i (nbf_ready_and_i)
    );

    always #5 clk_i = ~clk_i;

    // Record every flit transfer; inputs are stable around the falling edge.
    always @(negedge clk_i) begin
        if (!reset_i && nbf_v_o && nbf_ready_and_i) rcv_q.push_back(nbf_data_o);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] addr);
        int n = 0;
        s_axil_awaddr  = addr;
        s_axil_awvalid = 1'b1;
        while (!s_axil_awready && n < tmo) begin tick(); n++; end
        check("aw_accept", 32'(s_axil_awready), 32'd1);
        tick();
        s_axil_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        s_axil_wdata  = data;
        s_axil_wstrb  = strb;
        s_axil_wvalid = 1'b1;
        while (!s_axil_wready && n < tmo) begin tick(); n++; end
        check("w_accept", 32'(s_axil_wready), 32'd1);
        tick();
        s_axil_wvalid = 1'b0;
    endtask

    task automatic wait_b(input bit throttle, output logic [1:0] r);
        int         n = 0;
        logic       stalled;
        logic [1:0] prev;
        s_axil_bready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!(s_axil_bvalid && s_axil_bready) && n < tmo) begin
            stalled = s_axil_bvalid;
            prev    = s_axil_bresp;
            tick();
            n++;
            if (stalled) begin
                check("b_hold_valid", 32'(s_axil_bvalid), 32'd1);
                check("b_hold_resp", 32'(s_axil_bresp), 32'(prev));
            end
            s_axil_bready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check("b_valid", 32'(s_axil_bvalid), 32'd1);
        r = s_axil_bresp;
        tick();
        s_axil_bready = 1'b0;
        check("b_drop", 32'(s_axil_bvalid), 32'd0);
    endtask

    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input int aw_dly, input int w_dly, input bit throttle, output logic [1:0] r);
        fork
            begin repeat (aw_dly) tick(); send_aw(addr); end
            begin repeat (w_dly) tick(); send_w(data, strb); end
        join
        wait_b(throttle, r);
    endtask

    task automatic axil_read(input logic [31:0] addr, input bit throttle,
                             output logic [31:0] d, output logic [1:0] r);
        int          n = 0;
        logic        stalled;
        logic [31:0] pd;
        logic [1:0]  pr;
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        while (!s_axil_arready && n < tmo) begin tick(); n++; end
        check("ar_accept", 32'(s_axil_arready), 32'd1);
        tick();
        s_axil_arvalid = 1'b0;
        n = 0;
        s_axil_rready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!(s_axil_rvalid && s_axil_rready) && n < tmo) begin
            stalled = s_axil_rvalid;
            pd      = s_axil_rdata;
            pr      = s_axil_rresp;
            tick();
            n++;
            if (stalled) begin
                check("r_hold_valid", 32'(s_axil_rvalid), 32'd1);
                check("r_hold_data", s_axil_rdata, pd);
                check("r_hold_resp", 32'(s_axil_rresp), 32'(pr));
            end
            s_axil_rready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check("r_valid", 32'(s_axil_rvalid), 32'd1);
        d = s_axil_rdata;
        r = s_axil_rresp;
        tick();
        s_axil_rready = 1'b0;
        check("r_drop", 32'(s_axil_rvalid), 32'd0);
    endtask

    // Caller holds nbf_ready_and_i high; compares received flits against issued ones.
    task automatic drain_compare(input string tag);
        int n = 0;
        while (rcv_q.size() < exp_q.size() && n < 4 * tmo) begin tick(); n++; end
        check({tag, "_count"}, 32'(rcv_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++)
            check({tag, "_flit"}, rcv_q[i], exp_q[i]);
        exp_q.delete();
        rcv_q.delete();
    endtask

    initial begin
        reset_i         = 1'b1;
        s_axil_awaddr   = '0;
        s_axil_awvalid  = 1'b0;
        s_axil_wdata    = '0;
        s_axil_wstrb    = '0;
        s_axil_wvalid   = 1'b0;
        s_axil_bready   = 1'b0;
        s_axil_araddr   = '0;
        s_axil_arvalid  = 1'b0;
        s_axil_rready   = 1'b0;
        nbf_ready_and_i = 1'b0;
        t5_done         = 1'b0;
        repeat (3) tick();
        reset_i = 1'b0;
        tick();

        // Reset state
        check("rst_awready", 32'(s_axil_awready), 32'd1);
        check("rst_wready",  32'(s_axil_wready),  32'd1);
        check("rst_arready", 32'(s_axil_arready), 32'd1);
        check("rst_bvalid",  32'(s_axil_bvalid),  32'd0);
        check("rst_rvalid",  32'(s_axil_rvalid),  32'd0);
        check("rst_bresp",   32'(s_axil_bresp),   32'd0);
        check("rst_rresp",   32'(s_axil_rresp),   32'd0);
        check("rst_rdata",   s_axil_rdata,        32'd0);
        check("rst_nbf_v",   32'(nbf_v_o),        32'd0);

        // T1: AW first, W three cycles later
        send_aw(32'h0);
        repeat (2) tick();
        check("t1_awready_held", 32'(s_axil_awready), 32'd0);
        check("t1_wready_idle",  32'(s_axil_wready),  32'd1);
        check("t1_no_early_b",   32'(s_axil_bvalid),  32'd0);
        send_w(32'hDEADBEEF, 4'hF);
        exp_q.push_back(32'hDEADBEEF);
        wait_b(1'b0, resp);
        check("t1_bresp", 32'(resp), 32'(axi_resp_okay_gp));
        check("t1_nbf_v", 32'(nbf_v_o), 32'd1);
        check("t1_nbf_data", nbf_data_o, 32'hDEADBEEF);
        axil_read(32'h8, 1'b0, rdat, resp);
        check("t1_count", rdat, 32'd1);
        check("t1_count_resp", 32'(resp), 32'(axi_resp_okay_gp));
        axil_read(32'h4, 1'b0, rdat, resp);
        check("t1_free", rdat, 32'd15);
        nbf_ready_and_i = 1'b1;
        drain_compare("t1");
        nbf_ready_and_i = 1'b0;

        // T2: fill the FIFO, then one more write must stall the bus
        for (int i = 0; i < els; i++) begin
            wdat = 32'h1000_0000 + 32'(i);
            exp_q.push_back(wdat);
            axil_write(32'h0, wdat, 4'hF, 0, 0, 1'b0, resp);
            check("t2_bresp", 32'(resp), 32'(axi_resp_okay_gp));
        end
        wdat = 32'h1000_0010;
        exp_q.push_back(wdat);
        s_axil_awaddr  = 32'h0;
        s_axil_wdata   = wdat;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        tick();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        repeat (3) tick();
        check("t2_stall_awready", 32'(s_axil_awready), 32'd0);
        check("t2_stall_wready",  32'(s_axil_wready),  32'd0);
        check("t2_stall_no_b",    32'(s_axil_bvalid),  32'd0);
        axil_read(32'h4, 1'b0, rdat, resp);
        check("t2_free_full", rdat, 32'd0);
        nbf_ready_and_i = 1'b1;
        wait_b(1'b0, resp);
        check("t2_last_bresp", 32'(resp), 32'(axi_resp_okay_gp));
        drain_compare("t2");
        nbf_ready_and_i = 1'b0;

        // T3: partial strobe and write to a read-only register
        axil_write(32'h0, 32'hBAD0_0001, 4'h3, 0, 0, 1'b1, resp);
        check("t3_strb_slverr", 32'(resp), 32'(axi_resp_slverr_gp));
        axil_write(32'h4, 32'hBAD0_0002, 4'hF, 1, 0, 1'b1, resp);
        check("t3_ro_slverr", 32'(resp), 32'(axi_resp_slverr_gp));
        tick();
        check("t3_no_push", 32'(nbf_v_o), 32'd0);
        axil_read(32'h8, 1'b0, rdat, resp);
        check("t3_count", rdat, 32'd18);

        // T4: throttled reads of an unmapped address, the data address, and free space
        axil_read(32'hC, 1'b1, rdat, resp);
        check("t4_unmapped_data", rdat, 32'd0);
        check("t4_unmapped_resp", 32'(resp), 32'(axi_resp_slverr_gp));
        axil_read(32'h0, 1'b1, rdat, resp);
        check("t4_wo_data", rdat, 32'd0);
        check("t4_wo_resp", 32'(resp), 32'(axi_resp_slverr_gp));
        axil_read(32'h4, 1'b1, rdat, resp);
        check("t4_free_data", rdat, 32'(els));
        check("t4_free_resp", 32'(resp), 32'(axi_resp_okay_gp));

        // T6: reset with the FIFO half full, an AW held and an R pending
        for (int i = 0; i < els / 2; i++) begin
            axil_write(32'h0, 32'h2000_0000 + 32'(i), 4'hF, 0, 0, 1'b0, resp);
            check("t6_fill_bresp", 32'(resp), 32'(axi_resp_okay_gp));
        end
        axil_read(32'h4, 1'b0, rdat, resp);
        check("t6_free_half", rdat, 32'(els / 2));
        s_axil_awaddr  = 32'h0;
        s_axil_awvalid = 1'b1;
        s_axil_araddr  = 32'h8;
        s_axil_arvalid = 1'b1;
        tick();
        s_axil_awvalid = 1'b0;
        s_axil_arvalid = 1'b0;
        tick();
        check("t6_aw_held", 32'(s_axil_awready), 32'd0);
        check("t6_r_pending", 32'(s_axil_rvalid), 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("t6_nbf_v", 32'(nbf_v_o), 32'd0);
        check("t6_bvalid", 32'(s_axil_bvalid), 32'd0);
        check("t6_rvalid", 32'(s_axil_rvalid), 32'd0);
        check("t6_awready", 32'(s_axil_awready), 32'd1);
        check("t6_wready", 32'(s_axil_wready), 32'd1);
        repeat (3) tick();
        check("t6_no_stray_b", 32'(s_axil_bvalid), 32'd0);
        check("t6_no_stray_r", 32'(s_axil_rvalid), 32'd0);
        axil_read(32'h4, 1'b0, rdat, resp);
        check("t6_free", rdat, 32'(els));
        axil_read(32'h8, 1'b0, rdat, resp);
        check("t6_count", rdat, 32'd0);
        exp_q.delete();
        rcv_q.delete();

        // T5: long stream with random AW/W skew and random downstream ready
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    wdat = $urandom;
                    exp_q.push_back(wdat);
                    axil_write(32'h0, wdat, 4'hF, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, resp);
                    check("t5_bresp", 32'(resp), 32'(axi_resp_okay_gp));
                end
                t5_done = 1'b1;
            end
            begin
                while (!t5_done) begin
                    nbf_ready_and_i = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        nbf_ready_and_i = 1'b1;
        drain_compare("t5");
        axil_read(32'h8, 1'b0, rdat, resp);
        check("t5_count", rdat, 32'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
